opb_swreg_bank_ctrl: RTL and testbench

OPB_SWREG_BANK_CTRL -- requirements
Module: opb_swreg_bank_ctrl

---
 rtl/opb_swreg_bank_ctrl.sv | 147 ++++++++++++++
 tb/tb_opb_swreg_bank_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/opb_swreg_bank_ctrl.sv
// opb_swreg_bank_ctrl: OPB slave with four shadow registers committed to a live register bank
module opb_swreg_bank_ctrl #(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter int                      C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01014600,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h010146FF
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [4*C_OPB_DWIDTH-1:0]   user_data_out,
  output logic                        user_update
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam int NB = C_OPB_DWIDTH / 8;
  localparam logic [C_OPB_AWIDTH-1:0] OFF_CTRL = 'h10;
  localparam logic [C_OPB_AWIDTH-1:0] OFF_STAT = 'h14;

  logic [1:0]                         r_state;
  logic                               r_ack;
  logic                               r_rnw;
  logic                               r_auto;
  logic                               r_update;
  logic [C_OPB_AWIDTH-1:0]            r_off;
  logic [0:NB-1]                      r_be;
  logic [C_OPB_DWIDTH-1:0]            r_wdata;
  logic [C_OPB_DWIDTH-1:0]            r_rdata;
  logic [3:0][C_OPB_DWIDTH-1:0]       r_shadow;
  logic [3:0][C_OPB_DWIDTH-1:0]       r_live;
  logic [15:0]                        r_count;

  logic [C_OPB_AWIDTH-1:0]            w_off;
  logic                               w_hit;
  logic                               w_start;
  logic                               w_rd_sh;
  logic                               w_wr;
  logic                               w_sh_wr;
  logic                               w_ctrl_wr;
  logic                               w_commit;
  logic                               w_auto_ld;
  logic                               w_upd;
  logic                               w_unused;
  logic [1:0]                         w_idx;
  logic [C_OPB_DWIDTH-1:0]            w_rdata;
  logic [C_OPB_DWIDTH-1:0]            w_mask;
  logic [C_OPB_DWIDTH-1:0]            w_merged;

  assign w_unused   = OPB_seqAddr;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign Sl_xferAck = r_ack;
  assign Sl_DBus    = r_rdata;
  assign user_data_out = r_live;
  assign user_update   = r_update;

  // Address decode against the window; a new transfer starts only from IDLE
  assign w_off   = OPB_ABus - C_BASEADDR;
  assign w_hit   = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_start = (r_state == S_IDLE) && OPB_select && w_hit;
  assign w_rd_sh = (w_off[C_OPB_AWIDTH-1:4] == '0) && (w_off[1:0] == 2'b00);
  assign w_rdata = w_rd_sh              ? r_shadow[w_off[3:2]] :
                   (w_off == OFF_CTRL)  ? {{(C_OPB_DWIDTH-2){1'b0}}, r_auto, 1'b0} :
                   (w_off == OFF_STAT)  ? {{(C_OPB_DWIDTH-16){1'b0}}, r_count} :
                                          '0;

  // Byte lane mask: OPB_BE[0] covers the most significant byte
  for (genvar b = 0; b < NB; b++) begin : g_mask
    assign w_mask[8*b +: 8] = {8{r_be[NB-1-b]}};
  end

  // Write-side decode, evaluated in the ACK cycle from the latched transfer
  assign w_idx     = r_off[3:2];
  assign w_wr      = (r_state == S_ACK) && !r_rnw;
  assign w_sh_wr   = w_wr && (r_off[C_OPB_AWIDTH-1:4] == '0) && (r_off[1:0] == 2'b00);
  assign w_ctrl_wr = w_wr && (r_off == OFF_CTRL) && r_be[NB-1];
  assign w_commit  = w_ctrl_wr && r_wdata[0];
  assign w_auto_ld = w_sh_wr && r_auto;
  assign w_upd     = w_commit || w_auto_ld;
  assign w_merged  = (r_shadow[w_idx] & ~w_mask) | (r_wdata & w_mask);

  // Bus FSM with a registered single-cycle acknowledge and read data
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_start ? S_ACK :
                 ((r_state == S_ACK || r_state == S_WAIT) && OPB_select) ? S_WAIT : S_IDLE;
      r_ack   <= w_start;
      r_rdata <= (w_start && OPB_RNW) ? w_rdata : '0;
    end
  end

  // Capture the transfer attributes when it is accepted
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_off   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rnw   <= 1'b1;
    end else if (w_start) begin
      r_off   <= w_off;
      r_be    <= OPB_BE;
      r_wdata <= OPB_DBus;
      r_rnw   <= OPB_RNW;
    end
  end

  // Shadow registers and the AUTO control bit
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_shadow <= '0;
      r_auto   <= 1'b0;
    end else begin
      if (w_sh_wr) r_shadow[w_idx] <= w_merged;
      if (w_ctrl_wr) r_auto <= r_wdata[1];
    end
  end

  // Live bank load on commit or auto-update, with update pulse and commit counter
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_live   <= '0;
      r_update <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_commit) r_live <= r_shadow;
      else if (w_auto_ld) r_live[w_idx] <= w_merged;
      r_update <= w_upd;
      if (w_upd) r_count <= r_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_opb_swreg_bank_ctrl.sv
// tb_opb_swreg_bank_ctrl: directed self-checking bench for opb_swreg_bank_ctrl
module tb_opb_swreg_bank_ctrl;
  localparam logic [31:0] BASE = 32'h01014600;

  logic          OPB_Clk = 1'b0;
  logic          OPB_Rst = 1'b1;
  logic [0:31]   OPB_ABus = '0;
  logic [0:3]    OPB_BE = '0;
  logic [0:31]   OPB_DBus = '0;
  logic          OPB_RNW = 1'b0;
  logic          OPB_select = 1'b0;
  logic          OPB_seqAddr = 1'b0;
  logic [0:31]   Sl_DBus;
  logic          Sl_xferAck;
  logic          Sl_errAck;
  logic          Sl_retry;
  logic          Sl_toutSup;
  logic [127:0]  user_data_out;
  logic          user_update;

  int            checks = 0;
  int            failures = 0;
  int            lat;
  logic [31:0]   rd;
  logic          ack_after;
  int            acks;
  logic [31:0]   dbor;

  opb_swreg_bank_ctrl dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup), .user_data_out(user_data_out), .user_update(user_update)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge, returns one cycle after the acknowledge
  task automatic xfer(input logic [31:0] a, input logic rnw, input logic [3:0] be, input logic [31:0] d);
    OPB_ABus = a; OPB_RNW = rnw; OPB_BE = be; OPB_DBus = d; OPB_select = 1'b1;
    lat = 0; rd = '0;
    for (int i = 1; i <= 16 && lat == 0; i++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) begin lat = i; rd = Sl_DBus; end
    end
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    ack_after = Sl_xferAck;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [3:0] be, input logic [31:0] d);
    xfer(BASE + 32'(off), 1'b0, be, d);
    chk({tag, "_lat"}, 128'(lat), 128'd1);
  endtask

  task automatic rdchk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    xfer(BASE + 32'(off), 1'b1, 4'b1111, 32'h0);
    chk({tag, "_lat"}, 128'(lat), 128'd1);
    chk(tag, 128'(rd), 128'(exp));
  endtask

  task automatic probe_out(input string tag, input logic [31:0] a);
    OPB_ABus = a; OPB_RNW = 1'b1; OPB_BE = 4'b1111; OPB_select = 1'b1;
    acks = 0; dbor = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge OPB_Clk);
      acks += int'(Sl_xferAck);
      dbor |= Sl_DBus;
    end
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    chk({tag, "_ack"}, 128'(acks), 128'd0);
    chk({tag, "_dbus"}, 128'(dbor), 128'd0);
  endtask

  initial begin
    repeat (2) @(negedge OPB_Clk);
    chk("rst_ack", 128'(Sl_xferAck), 128'd0);
    chk("rst_dbus", 128'(Sl_DBus), 128'd0);
    chk("rst_udo", user_data_out, 128'd0);
    chk("rst_upd", 128'(user_update), 128'd0);
    chk("tieoffs", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'd0);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    rdchk("status_init", 8'h14, 32'h0);

    wr("wr_dead", 8'h04, 4'b1111, 32'hDEADBEEF);
    chk("wr_dbus_zero", 128'(rd), 128'd0);
    chk("ack_single", 128'(ack_after), 128'd0);
    chk("wr_no_upd", 128'(user_update), 128'd0);
    chk("wr_udo_same", user_data_out, 128'd0);
    rdchk("rd_dead", 8'h04, 32'hDEADBEEF);

    wr("sh0", 8'h00, 4'b1111, 32'h1);
    wr("sh1", 8'h04, 4'b1111, 32'h2);
    wr("sh2", 8'h08, 4'b1111, 32'h3);
    wr("sh3", 8'h0C, 4'b1111, 32'h4);
    wr("commit", 8'h10, 4'b1111, 32'h1);
    chk("commit_upd", 128'(user_update), 128'd1);
    chk("commit_udo", user_data_out, {32'h4, 32'h3, 32'h2, 32'h1});
    @(negedge OPB_Clk);
    chk("commit_pulse_end", 128'(user_update), 128'd0);
    rdchk("status_1", 8'h14, 32'h1);
    rdchk("ctrl_0", 8'h10, 32'h0);

    wr("auto_on", 8'h10, 4'b1111, 32'h2);
    chk("auto_on_noupd", 128'(user_update), 128'd0);
    rdchk("ctrl_auto", 8'h10, 32'h2);
    wr("auto_full", 8'h08, 4'b1111, 32'h11223344);
    chk("auto_full_upd", 128'(user_update), 128'd1);
    chk("auto_full_udo", user_data_out, {32'h4, 32'h11223344, 32'h2, 32'h1});
    wr("auto_byte", 8'h08, 4'b0001, 32'hFFFFFFAB);
    chk("auto_byte_upd", 128'(user_update), 128'd1);
    chk("auto_byte_udo", user_data_out, {32'h4, 32'h112233AB, 32'h2, 32'h1});
    rdchk("status_3", 8'h14, 32'h3);

    wr("commit_auto", 8'h10, 4'b1111, 32'h3);
    chk("ca_upd", 128'(user_update), 128'd1);
    @(negedge OPB_Clk);
    chk("ca_pulse_end", 128'(user_update), 128'd0);
    rdchk("status_4", 8'h14, 32'h4);
    rdchk("ctrl_auto_kept", 8'h10, 32'h2);

    wr("rsvd_wr", 8'h18, 4'b1111, 32'hFFFFFFFF);
    chk("rsvd_noupd", 128'(user_update), 128'd0);
    rdchk("rsvd_rd", 8'h18, 32'h0);
    rdchk("top_rd", 8'hFC, 32'h0);
    wr("status_wr", 8'h14, 4'b1111, 32'h0);
    rdchk("status_ro", 8'h14, 32'h4);

    probe_out("above", 32'h01014700);
    probe_out("below", 32'h010145FC);

    OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'b1111; OPB_DBus = 32'h77; OPB_select = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge OPB_Clk);
      acks += int'(Sl_xferAck);
    end
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    chk("held_one_ack", 128'(acks), 128'd1);
    rdchk("held_wr", 8'h00, 32'h77);

    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    rdchk("status_ffff", 8'h14, 32'hFFFF);
    wr("wrap_commit", 8'h10, 4'b1111, 32'h3);
    chk("wrap_upd", 128'(user_update), 128'd1);
    rdchk("status_wrap", 8'h14, 32'h0);

    OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'b1111; OPB_DBus = 32'h55; OPB_select = 1'b1;
    @(negedge OPB_Clk);
    chk("pre_rst_ack", 128'(Sl_xferAck), 128'd1);
    OPB_Rst = 1'b1;
    #1;
    chk("rst_ack_now", 128'(Sl_xferAck), 128'd0);
    chk("rst_dbus_now", 128'(Sl_DBus), 128'd0);
    chk("rst_udo_now", user_data_out, 128'd0);
    OPB_select = 1'b0;
    repeat (2) @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    rdchk("post_rst_sh0", 8'h00, 32'h0);
    rdchk("post_rst_ctrl", 8'h10, 32'h0);
    rdchk("post_rst_status", 8'h14, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
